alu_wb_queue: RTL

ALU_WB_QUEUE -- requirements
Module: alu_wb_queue

---
 rtl/alu_wb_queue_if.sv | 37 +++
 rtl/alu_wb_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/alu_wb_queue_if.sv
// ALU-to-writeback handshake bundle: producer side (ALU), consumer side (writeback),
// fetch redirect and pipeline flush. The queue uses the slave modport.
interface alu_wb_queue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_tag;
  logic [4:0]  in_rd;
  logic [63:0] in_result;
  logic        in_take_branch;
  logic        in_is_branch;
  logic        in_pred_taken;
  logic [63:0] in_pc;
  logic [63:0] in_target;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_mispredict;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport slave (
    input  flush, in_valid, in_tag, in_rd, in_result, in_take_branch,
           in_is_branch, in_pred_taken, in_pc, in_target, wb_ready,
    output in_ready, wb_valid, wb_tag, wb_rd, wb_data, wb_mispredict,
           redirect_valid, redirect_pc
  );

  modport master (
    output flush, in_valid, in_tag, in_rd, in_result, in_take_branch,
           in_is_branch, in_pred_taken, in_pc, in_target, wb_ready,
    input  in_ready, wb_valid, wb_tag, wb_rd, wb_data, wb_mispredict,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/alu_wb_queue.sv
// 4-entry ALU writeback queue with branch-mispredict redirect generation.
// Optional macro ALU_WB_BYPASS_EN: an input hitting an empty queue with wb_ready goes straight to wb_*.
module alu_wb_queue (
  input  logic           clk,
  input  logic           reset,
  alu_wb_queue_if.slave  bus
);

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [5:0]        tag;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic              mispredict;
  } entry_t;

  entry_t            entry_q [DEPTH];
  entry_t            entry_d [DEPTH];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  entry_t            new_entry;
  entry_t            head;
  logic              mispredict_in;
  logic              accept;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              not_empty;

  function automatic logic [DATA_W-1:0] fix_pc(input logic              take,
                                               input logic [DATA_W-1:0] pc,
                                               input logic [DATA_W-1:0] target);
    fix_pc = take ? target : pc + DATA_W'(4);
  endfunction

  assign not_empty   = (count_q != 3'd0);
  assign bus.in_ready = (count_q < 3'(DEPTH));

  always_comb begin
    mispredict_in = bus.in_is_branch && (bus.in_take_branch != bus.in_pred_taken);
    new_entry.tag        = bus.in_tag;
    new_entry.rd         = bus.in_is_branch ? 5'd0 : bus.in_rd;
    new_entry.data       = bus.in_result;
    new_entry.mispredict = mispredict_in;

    accept = bus.in_valid && bus.in_ready && !bus.flush;
`ifdef ALU_WB_BYPASS_EN
    bypass = !not_empty && bus.in_valid && bus.wb_ready && !bus.flush;
`else
    bypass = 1'b0;
`endif
    push = accept && !bypass;
    pop  = not_empty && bus.wb_ready && !bus.flush;
  end

  // Head selection: stored entry, bypassed input, or zeros when idle
  always_comb begin
    head = entry_q[rd_ptr_q];
    if (!not_empty) begin
      head = bypass ? new_entry : '0;
    end
    bus.wb_valid      = not_empty || bypass;
    bus.wb_tag        = head.tag;
    bus.wb_rd         = head.rd;
    bus.wb_data       = head.data;
    bus.wb_mispredict = head.mispredict;
  end

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + 3'(push) - 3'(pop);
    if (bus.flush) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end

    // Redirect is taken from every accepted mispredict, bypassed or queued
    redirect_valid_d = accept && mispredict_in;
    redirect_pc_d    = redirect_valid_d
                     ? fix_pc(bus.in_take_branch, bus.in_pc, bus.in_target)
                     : redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q         <= 2'd0;
      rd_ptr_q         <= 2'd0;
      count_q          <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Entry storage is not reset; it is only visible through head when count != 0
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule
